// File: rtl/regfile_sb_pkg.sv
// Shared register-file definitions: clear-engine state encoding and the
// default geometry reused by decode and writeback.
package regfile_sb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regfile_state_e;

    localparam int unsigned DEF_REG_WIDTH = 32;
    localparam int unsigned DEF_REG_DEPTH = 32;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reservations,
// cleared by writeback or a global flush. Bit 0 never reads busy.
module regfile_sb_scoreboard #(
    parameter int RegDepth = 32,
    parameter int NumRead  = 2,
    parameter int AddrW    = $clog2(RegDepth)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            set_en,
    input  logic [AddrW-1:0]                set_addr,
    input  logic                            clr_en,
    input  logic [AddrW-1:0]                clr_addr,
    input  logic                            flush,
    input  logic [NumRead-1:0][AddrW-1:0]   lookup_addr,
    output logic [NumRead-1:0]              busy
);

    logic [RegDepth-1:0] sb;

    // Flush beats everything; a same-cycle set beats a clear of the same bit.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sb <= '0;
        end else begin
            if (clr_en) sb[clr_addr] <= 1'b0;
            if (set_en) sb[set_addr] <= 1'b1;
            sb[0] <= 1'b0;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NumRead; i++) begin
            busy[i] = sb[lookup_addr[i]];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// x0-hardwired register file with multi-port reads, optional write bypass,
// a pending-write scoreboard and a post-reset sequential clear sweep.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int RegWidth = DEF_REG_WIDTH,
    parameter  int RegDepth = DEF_REG_DEPTH,
    parameter  int NumRead  = 2,
    parameter  int Bypass   = 1,
    localparam int AddrW    = $clog2(RegDepth)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumRead-1:0][AddrW-1:0]   rs_addr_i,
    output logic [NumRead-1:0][RegWidth-1:0] rs_data_o,
    output logic [NumRead-1:0]              rs_busy_o,
    input  logic                            rd_write_en_i,
    input  logic [AddrW-1:0]                rd_addr_i,
    input  logic [RegWidth-1:0]             rd_data_i,
    input  logic                            resv_en_i,
    input  logic [AddrW-1:0]                resv_addr_i,
    input  logic                            flush_i,
    output logic                            ready_o,
    output logic                            dbg_state_o
);

    regfile_state_e      state;
    logic [AddrW-1:0]    idx;
    logic [RegWidth-1:0] regs [RegDepth];
    logic                run;
    logic                wr_ok;
    logic                resv_ok;
    logic [NumRead-1:0]  sb_busy;

    assign run         = (state == RUN);
    assign wr_ok       = run && rd_write_en_i && (rd_addr_i != '0);
    assign resv_ok     = run && resv_en_i && (resv_addr_i != '0);
    assign dbg_state_o = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR;
            idx     <= AddrW'(1);
            ready_o <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= idx + AddrW'(1);
                    if (idx == AddrW'(RegDepth - 1)) begin
                        state   <= RUN;
                        ready_o <= 1'b1;
                    end
                end
                RUN: begin
                    state   <= RUN;
                    ready_o <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Data array has no reset; the sweep is the only thing that zeroes it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == CLEAR) begin
                regs[idx] <= '0;
            end else if (wr_ok) begin
                regs[rd_addr_i] <= rd_data_i;
            end
        end
    end

    regfile_sb_scoreboard #(
        .RegDepth (RegDepth),
        .NumRead  (NumRead),
        .AddrW    (AddrW)
    ) u_scoreboard (
        .clk         (clk_i),
        .rst         (rst_i),
        .set_en      (resv_ok),
        .set_addr    (resv_addr_i),
        .clr_en      (wr_ok),
        .clr_addr    (rd_addr_i),
        .flush       (run && flush_i),
        .lookup_addr (rs_addr_i),
        .busy        (sb_busy)
    );

    always_comb begin
        rs_data_o = '0;
        rs_busy_o = '0;
        for (int i = 0; i < NumRead; i++) begin
            if (run && (rs_addr_i[i] != '0)) begin
                if ((Bypass != 0) && wr_ok && (rd_addr_i == rs_addr_i[i])) begin
                    rs_data_o[i] = rd_data_i;
                    rs_busy_o[i] = 1'b0;
                end else begin
                    rs_data_o[i] = regs[rs_addr_i[i]];
                    rs_busy_o[i] = sb_busy[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance
// share stimulus; expected values go through a queue and are popped at each check.
module tb_regfile_sb;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][4:0]  rs_addr;
    logic             we;
    logic [4:0]       rd_addr;
    logic [31:0]      rd_data;
    logic             resv_en;
    logic [4:0]       resv_addr;
    logic             flush;

    logic [1:0][31:0] data_a, data_b;
    logic [1:0]       busy_a, busy_b;
    logic             ready_a, ready_b;
    logic             state_a, state_b;

    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.Bypass(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(data_a),
        .rs_busy_o(busy_a), .rd_write_en_i(we), .rd_addr_i(rd_addr),
        .rd_data_i(rd_data), .resv_en_i(resv_en), .resv_addr_i(resv_addr),
        .flush_i(flush), .ready_o(ready_a), .dbg_state_o(state_a)
    );

    regfile_sb #(.Bypass(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(data_b),
        .rs_busy_o(busy_b), .rd_write_en_i(we), .rd_addr_i(rd_addr),
        .rd_data_i(rd_data), .resv_en_i(resv_en), .resv_addr_i(resv_addr),
        .flush_i(flush), .ready_o(ready_b), .dbg_state_o(state_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rd_addr = '0; rd_data = '0;
        resv_en = 1'b0; resv_addr = '0; flush = 1'b0;
    endtask

    task automatic exp_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic sweep_and_count(input string tag);
        int n;
        n = 0;
        while (!ready_a && n < 40) begin
            step();
            n++;
        end
        exp_push(32'd31);
        chk(tag, n);
    endtask

    initial begin
        rst = 1'b1;
        rs_addr = '0;
        idle();
        repeat (2) step();
        rs_addr[0] = 5'd5; rs_addr[1] = 5'd7;
        #1;
        exp_push(0); chk("rst_ready_a", {31'd0, ready_a});
        exp_push(0); chk("rst_ready_b", {31'd0, ready_b});
        exp_push(0); chk("rst_data0", data_a[0]);
        exp_push(0); chk("rst_busy", {30'd0, busy_a});

        // Sweep: late in CLEAR, a write and reservation of x2 must be ignored.
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            if (k >= 20) begin
                we = 1'b1; rd_addr = 5'd2; rd_data = 32'h55;
                resv_en = 1'b1; resv_addr = 5'd2; rs_addr[0] = 5'd2;
            end
            if (k == 25) begin
                #1;
                exp_push(0); chk("clear_bypass_blocked", data_a[0]);
                exp_push(0); chk("clear_busy", {30'd0, busy_a});
            end
            step();
            exp_push((k == 31) ? 32'd1 : 32'd0); chk("sweep_ready", {31'd0, ready_a});
        end
        idle();
        #1;
        exp_push(1); chk("run_state", {31'd0, state_a});
        exp_push(0); chk("x2_after_clear", data_a[0]);
        exp_push(0); chk("x2_busy_after_clear", {31'd0, busy_a[0]});
        exp_push(0); chk("x7_after_clear", data_a[1]);

        // Write x5 with port0 watching: bypass vs no bypass.
        rs_addr[0] = 5'd5;
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        #1;
        exp_push(32'hDEADBEEF); chk("bypass_same_cycle", data_a[0]);
        exp_push(0);            chk("nobypass_same_cycle", data_b[0]);
        step(); idle(); #1;
        exp_push(32'hDEADBEEF); chk("x5_next_a", data_a[0]);
        exp_push(32'hDEADBEEF); chk("x5_next_b", data_b[0]);

        // Reserve x7, then write+reserve x7 together.
        rs_addr[1] = 5'd7;
        resv_en = 1'b1; resv_addr = 5'd7;
        #1;
        exp_push(0); chk("x7_busy_before_edge", {31'd0, busy_a[1]});
        step(); idle(); #1;
        exp_push(1); chk("x7_busy_a", {31'd0, busy_a[1]});
        exp_push(1); chk("x7_busy_b", {31'd0, busy_b[1]});
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h12;
        resv_en = 1'b1; resv_addr = 5'd7;
        #1;
        exp_push(32'h12); chk("x7_bypass_data", data_a[1]);
        exp_push(0);      chk("x7_bypass_busy_mask", {31'd0, busy_a[1]});
        exp_push(1);      chk("x7_nobypass_busy", {31'd0, busy_b[1]});
        step(); idle(); #1;
        exp_push(32'h12); chk("x7_data_a", data_a[1]);
        exp_push(32'h12); chk("x7_data_b", data_b[1]);
        exp_push(1);      chk("x7_resv_wins", {31'd0, busy_a[1]});

        // Reserve x3, x4, x9 then flush; flush also beats a same-cycle reservation.
        resv_en = 1'b1;
        resv_addr = 5'd3; step();
        resv_addr = 5'd4; step();
        resv_addr = 5'd9; step();
        idle();
        rs_addr[0] = 5'd3; rs_addr[1] = 5'd9;
        #1;
        exp_push(32'h3); chk("pre_flush_busy", {30'd0, busy_a});
        flush = 1'b1; resv_en = 1'b1; resv_addr = 5'd4;
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'h99;
        step(); idle();
        #1;
        exp_push(0); chk("flush_busy_3_9", {30'd0, busy_a});
        exp_push(32'h99); chk("flush_write_kept", data_a[1]);
        rs_addr[0] = 5'd4; rs_addr[1] = 5'd7;
        #1;
        exp_push(0); chk("flush_beats_resv", {31'd0, busy_a[0]});
        exp_push(0); chk("flush_x7_busy", {31'd0, busy_a[1]});
        exp_push(32'h12); chk("flush_x7_data", data_a[1]);
        rs_addr[0] = 5'd5;
        #1;
        exp_push(32'hDEADBEEF); chk("flush_x5_data", data_a[0]);

        // x0 is hardwired.
        rs_addr[0] = 5'd0;
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
        resv_en = 1'b1; resv_addr = 5'd0;
        #1;
        exp_push(0); chk("x0_bypass", data_a[0]);
        step(); idle(); #1;
        exp_push(0); chk("x0_data", data_a[0]);
        exp_push(0); chk("x0_busy", {31'd0, busy_a[0]});

        // Write x20, then a reset mid-sweep must re-run the whole clear.
        rs_addr[0] = 5'd20;
        we = 1'b1; rd_addr = 5'd20; rd_data = 32'd5;
        step(); idle(); #1;
        exp_push(5); chk("x20_written", data_a[0]);
        rst = 1'b1;
        step();
        exp_push(0); chk("reset_drops_ready", {31'd0, ready_a});
        rst = 1'b0;
        repeat (9) step();
        exp_push(0); chk("mid_sweep_ready", {31'd0, ready_a});
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep_and_count("resweep_edges");
        exp_push(1); chk("resweep_ready_b", {31'd0, ready_b});
        exp_push(0); chk("x20_cleared", data_a[0]);
        exp_push(0); chk("x20_busy", {31'd0, busy_a[0]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the core's integer register file: an x0-hardwired register file with `NumRead` read ports, one write port, optional write-to-read bypass, a per-register scoreboard of pending writes, and a post-reset sequential clear engine. It sits in the decode/issue stage. Decode reserves destinations and checks source readiness. Writeback writes results and retires the reservations.

## Interface
- `RegWidth`, 32, data width of each register.
- `RegDepth`, 32, number of architectural registers including x0; must be ≥ 2.
- `NumRead`, 2, number of independent read ports; must be ≥ 1.
- `Bypass`, 1, 1 forwards the same-cycle write data to matching read ports; 0 disables forwarding.
- `AddrW` is a derived localparam equal to `$clog2(RegDepth)`.
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `rs_addr_i` in `NumRead`×`AddrW`: read address, one per port.
- `rs_data_o` out `NumRead`×`RegWidth`: read data, one per port.
- `rs_busy_o` out `NumRead`: source has a pending write, one per port.
- `rd_write_en_i` in 1: write enable.
- `rd_addr_i` in `AddrW`: write address.
- `rd_data_i` in `RegWidth`: write data.
- `resv_en_i` in 1: reserve a destination, i.e. set its scoreboard bit.
- `resv_addr_i` in `AddrW`: address to reserve.
- `flush_i` in 1: clear every scoreboard bit.
- `ready_o` out 1: the clear sweep is done and the block accepts writes and reservations.

## Operation
- Two-state FSM, `CLEAR` and `RUN`.
  - Reset puts the FSM in `CLEAR`, sets the sweep index to 1, and zeroes all scoreboard bits.
  - In `CLEAR`, each cycle with `rst_i` low writes 0 to `regs[idx]` and increments `idx`.
  - The cycle that clears `regs[RegDepth-1]` moves the FSM to `RUN`. `RUN` is held until the next reset.
- Reset does not clear the data array in parallel. Only the sweep clears it.
- Behaviour in `CLEAR`:
  - `ready_o` is 0.
  - `rd_write_en_i`, `resv_en_i` and `flush_i` are ignored.
  - All `rs_data_o` read 0 and all `rs_busy_o` read 0.
- Reads in `RUN` are combinational.
  - Address 0 always returns data 0 and busy 0.
  - Otherwise the port returns `regs[a]`, or `rd_data_i` when all of the following hold: `Bypass`=1, `rd_write_en_i`=1, and `rd_addr_i`=`a`.
- Busy flag per port:
  - `rs_busy_o` = `sb[a]`.
  - With `Bypass`=1 it is additionally masked to 0 when a same-cycle write targets `a`.
- Writes in `RUN`:
  - A write to address 0 is dropped.
  - Any other write updates the register and clears `sb[rd_addr_i]`.
  - A write to an unreserved register is legal and has no side effect on other bits.
- Reservations in `RUN`:
  - `resv_en_i` with a nonzero address sets `sb[resv_addr_i]`.
  - A reservation of address 0 is dropped.
- Simultaneous events in the same cycle, same address:
  - Reservation and write together: the data is written and the reservation wins, so `sb`=1 afterwards.
  - `flush_i` with anything: flush clears every bit, including a same-cycle reservation.
  - The data write still happens.

## Timing
- Reset values:
  - `ready_o`=0.
  - All `rs_busy_o`=0 and all `rs_data_o`=0.
  - `sb`=0 for every register.
- `ready_o` rises after exactly `RegDepth-1` rising edges with `rst_i` low; this is 31 edges at the defaults.
- Read latency is 0 cycles (combinational).
- Write and reservation results are visible through the array one cycle after the edge.
- With `Bypass`=1, write data is also visible in the same cycle through the bypass path.
- Reset asserted mid-sweep or mid-run:
  - On the next edge the FSM returns to `CLEAR`, `idx` returns to 1, and `sb` is cleared.
  - A full sweep runs again.

## Structure
- The core's shared package holds:
  - the `regfile_state_e` enum (`CLEAR`, `RUN`);
  - the default `RegWidth` and `RegDepth` constants, reused by decode and writeback.
- One sub-module, `scoreboard`, parametrised by `RegDepth`:
  - inputs: set, clear and flush;
  - outputs: `NumRead` busy lookups;
  - bit 0 is tied to 0.
- The data array, bypass muxing and clear FSM live in `regfile_sb`.

## Test plan
- Reset for 2 cycles, then release. `ready_o`=0 for edges 1–30 and goes to 1 after edge 31. All reads then return 0 with busy 0.
- In `RUN`, write `x5`=`0xDEADBEEF` with port0 reading `x5`. With `Bypass`=1, `rs_data_o[0]`=`0xDEADBEEF` in the same cycle. With `Bypass`=0 it returns the old value 0 and the new value from the next cycle.
- Reserve `x7`, so port1 `busy`=1. Next, write `x7`=`0x12` and reserve `x7` in the same cycle. The value reads `0x12` and `busy` stays 1.
- Reserve `x3`, `x4` and `x9`, then assert `flush_i`. All busy flags read 0 next cycle and register contents are unchanged.
- Write `x0`=`0xFFFFFFFF` and reserve `x0`. Reads of `x0` return data 0 and busy 0.
- Assert reset mid-sweep (edge 10) after a prior `RUN`-state write of `x20`=5. `ready_o` drops, the full sweep repeats, and `x20` reads 0 once `ready_o`=1.
